// File: rtl/rf_mp_sb.sv
// rf_mp_sb: multi-port register file with two prioritised write ports, optional bypass, busy scoreboard
// and a sequential clear sweep after reset. Define RF_WCNT_EN to add the wr_cnt accepted-write counter.
module rf_mp_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2,
    parameter int BYPASS     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rbusy,
    input  logic                        wen0,
    input  logic [ADDR_WIDTH-1:0]       waddr0,
    input  logic [DATA_WIDTH-1:0]       wdata0,
    input  logic                        wen1,
    input  logic [ADDR_WIDTH-1:0]       waddr1,
    input  logic [DATA_WIDTH-1:0]       wdata1,
    input  logic                        alloc_en,
    input  logic [ADDR_WIDTH-1:0]       alloc_addr,
    output logic                        ready
`ifdef RF_WCNT_EN
    ,
    output logic [31:0]                 wr_cnt
`endif
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t                r_state;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_rf [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic                  w_we0;
    logic                  w_we1;
    assign w_we0 = r_state == RUN && wen0 && waddr0 != '0;
    assign w_we1 = r_state == RUN && wen1 && waddr1 != '0;
    assign ready = r_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= ADDR_WIDTH'(1);
            r_busy  <= '0;
            r_ready <= 1'b0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
            if (r_cnt == '1) begin
                r_state <= RUN;
                r_ready <= 1'b1;
            end
        end else begin
            // a new allocation outranks a completing write to the same register
            for (int r = 1; r < DEPTH; r++)
                r_busy[r] <= (alloc_en && alloc_addr == ADDR_WIDTH'(r)) ? 1'b1 :
                             ((w_we0 && waddr0 == ADDR_WIDTH'(r)) || (w_we1 && waddr1 == ADDR_WIDTH'(r))) ? 1'b0 :
                             r_busy[r];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && r_state == CLEAR) begin
            r_rf[r_cnt] <= '0;
        end else if (!rst) begin
            if (w_we0) r_rf[waddr0] <= wdata0;
            if (w_we1) r_rf[waddr1] <= wdata1;
        end
    end
`ifdef RF_WCNT_EN
    logic [31:0] r_wr_cnt;
    assign wr_cnt = r_wr_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_wr_cnt <= '0;
        else
            r_wr_cnt <= r_wr_cnt + {31'b0, w_we1} + {31'b0, w_we0 && !(w_we1 && waddr1 == waddr0)};
    end
`endif
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        assign w_ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] =
            (r_state != RUN || w_ra == '0)              ? '0     :
            (BYPASS != 0 && w_we1 && waddr1 == w_ra)    ? wdata1 :
            (BYPASS != 0 && w_we0 && waddr0 == w_ra)    ? wdata0 :
            r_rf[w_ra];
        assign rbusy[i] = r_state == RUN && r_busy[w_ra];
    end
endmodule

// File: doc/rf_mp_sb.md
Name: rf_mp_sb

Overview:
- Parametrised multi-port integer register file for the NPC datapath; successor to the single-write, two-read RF.
- Adds NREAD read ports, two write ports with fixed priority, optional write-to-read bypass, and a per-register busy scoreboard for issue/hazard logic.
- Clears all registers after reset with a sweeping sequential clear, and signals availability on `ready`.
- Register 0 is hard-wired to zero and is never busy.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- NREAD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- raddr  in  NREAD*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NREAD*DATA_WIDTH  read data, combinational, same slicing as raddr.
- rbusy  out  NREAD  scoreboard busy bit of raddr[i].
- wen0  in  1  write port 0 enable.
- waddr0  in  ADDR_WIDTH  write port 0 address.
- wdata0  in  DATA_WIDTH  write port 0 data.
- wen1  in  1  write port 1 enable; has priority over port 0.
- waddr1  in  ADDR_WIDTH  write port 1 address.
- wdata1  in  DATA_WIDTH  write port 1 data.
- alloc_en  in  1  marks alloc_addr busy (instruction issued with this destination).
- alloc_addr  in  ADDR_WIDTH  destination being allocated.
- ready  out  1  high once the clear sweep has completed.

Behaviour:
- States: CLEAR, RUN. A clear counter `cnt` (ADDR_WIDTH bits) is internal.
- Any edge with rst=1: state=CLEAR, cnt=1, all busy bits cleared, ready=0. Applies equally to reset mid-operation (restarts the sweep).
- CLEAR, rst=0: each edge writes 0 to rf[cnt] and increments cnt.
  - On the edge where cnt == 2**ADDR_WIDTH-1: that entry is cleared and state goes to RUN.
  - ready=1 from that point, i.e. 2**ADDR_WIDTH-1 edges after the first rst=0 edge (31 for defaults).
- During CLEAR: wen0/wen1/alloc_en are ignored, rdata = 0 and rbusy = 0 on all ports.
- RUN, writes:
  - On each edge, wenN && waddrN != 0 writes wdataN.
  - Same address on both ports: port 1 value is stored.
  - Writes to address 0 are dropped.
- RUN, reads (combinational, zero latency):
  - raddr == 0 returns 0.
  - Else if BYPASS=1 and wen1 && waddr1 == raddr, return wdata1.
  - Else if BYPASS=1 and wen0 && waddr0 == raddr, return wdata0.
  - Else return the stored value.
  - With BYPASS=0 the value written appears on the cycle after the edge.
- Scoreboard, per register r != 0, evaluated each edge in RUN:
  - Set if alloc_en && alloc_addr == r.
  - Else clear if a write to r is accepted on either port.
  - Else hold.
  - Alloc and write to the same register in the same cycle: busy stays 1 (the new producer wins).
  - alloc_addr == 0 is ignored.
- rbusy[i] = busy[raddr[i]], registered state only, with no bypass of the same-cycle alloc or write. x0 always reads 0.
- Reset values: ready=0, rbusy=0, rdata=0 (driven 0 during CLEAR).

Optional Feature:
- Macro: RF_WCNT_EN.
- Defined:
  - Adds output port `wr_cnt` (out, 32 bits): count of accepted non-x0 write-port operations.
  - Two writes in one cycle to different registers add 2.
  - Two writes to the same register add 1.
  - Cleared by rst, wraps modulo 2**32, does not count during CLEAR.
- Not defined: the port and counter are absent; no other behaviour changes.

Test Plan:
- Reset sweep: rst=1 for 2 cycles, then 0 → ready=0 for exactly 31 edges and 1 afterwards. Reading raddr=5 before and after the sweep returns 0. wen0 to x3 issued mid-sweep leaves x3 = 0.
- Dual write collision: waddr0=waddr1=7, wdata0=0x11, wdata1=0x22 → next cycle x7 = 0x22. With RF_WCNT_EN, wr_cnt increments by 1.
- Bypass: BYPASS=1, wen1 to x9 with 0xDEADBEEF and raddr0=9 in the same cycle → rdata0 = 0xDEADBEEF combinationally. BYPASS=0 → the old value that cycle, 0xDEADBEEF on the next.
- Scoreboard: alloc x4 → rbusy=1 the next cycle. Then wen0 to x4 → rbusy=0 the next cycle. Alloc and write to x4 in the same cycle → rbusy stays 1.
- x0 handling: wen0 to x0 with 0x55, plus alloc x0 → raddr=0 gives rdata=0 and rbusy=0.
- Reset mid-run: x2 busy and holding 0x1234, assert rst for 1 cycle → rbusy=0 and ready=0 immediately. After 31 edges, x2 reads 0.
